// File: rtl/ctr_drbg_pkg.sv
// ---------------------------------------------------------------------------
// ctr_drbg_pkg
//
// Shared definitions for the CTR_DRBG Generate engine:
//   - working-state widths (block, key, seed) and matching typedefs
//   - FSM state encoding used by ctr_drbg_generate
//   - encrypt_stub(): stand-in block cipher, Encrypt(K,V) = V ^ K
//
// No ports; imported by every RTL file of the engine.
// ---------------------------------------------------------------------------
package ctr_drbg_pkg;

    localparam int BLOCKLEN = 128;
    localparam int KEYLEN   = 128;
    localparam int SEEDLEN  = KEYLEN + BLOCKLEN;

    typedef logic [KEYLEN-1:0]   key_t;
    typedef logic [BLOCKLEN-1:0] block_t;
    typedef logic [SEEDLEN-1:0]  seed_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_GEN   = 3'd2,
        ST_UPD0  = 3'd3,
        ST_UPD1  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    // Stand-in cipher with the same interface as AES: keeps the data
    // dependency on both key and counter so the surrounding datapath is
    // exercised the same way.
    function automatic block_t encrypt_stub(key_t key, block_t v);
        return v ^ block_t'(key);
    endfunction

endpackage

// File: rtl/ctr_drbg_block_cipher.sv
// ---------------------------------------------------------------------------
// ctr_drbg_block_cipher
//
// Pipelined block-cipher wrapper with a fixed latency of ENC_LAT cycles.
// A block presented with start=1 is captured on that clock edge; its result
// appears on result with done=1 for one cycle, ENC_LAT edges later.  A new
// start may be issued every cycle.  Replacing the stub with a real AES core
// only touches this module.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       capture key/block this cycle
//   key         cipher key
//   block       plaintext block (the incremented V counter)
//   done        one-cycle pulse, result valid
//   result      ciphertext block
// ---------------------------------------------------------------------------
module ctr_drbg_block_cipher
    import ctr_drbg_pkg::*;
#(
    parameter int ENC_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEYLEN-1:0]   key,
    input  logic [BLOCKLEN-1:0] block,
    output logic                done,
    output logic [BLOCKLEN-1:0] result
);

    logic [ENC_LAT-1:0] stage_valid;
    block_t             stage_data [ENC_LAT];

    // NOTE: sequential state is written with non-blocking assignments so
    // every stage samples the value its predecessor held before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
        end else begin
            stage_valid[0] <= start;
            for (int i = 1; i < ENC_LAT; i++) begin
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    // NOTE: the data pipeline is deliberately left without reset; only the
    // valid bits qualify it, so resetting 128-bit stages would buy nothing.
    always_ff @(posedge clk) begin
        stage_data[0] <= encrypt_stub(key, block);
        for (int i = 1; i < ENC_LAT; i++) begin
            stage_data[i] <= stage_data[i-1];
        end
    end

    assign done   = stage_valid[ENC_LAT-1];
    assign result = stage_data[ENC_LAT-1];

endmodule

// File: rtl/ctr_drbg_generate.sv
// ---------------------------------------------------------------------------
// ctr_drbg_generate
//
// CTR_DRBG Generate engine.  Accepts one request at a time, checks the reseed
// counter and block count, streams req_nblocks encrypted counter blocks
// (V+1, V+2, ...) to the consumer, then runs the update step (two more
// encryptions XOR additional input) and returns the new Key/V/reseed counter.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       request present
//   req_ready       high only while idle
//   req_nblocks     number of output blocks requested (1..MAX_BLOCKS)
//   key_in, v_in    current working state
//   add_in          additional input (all-zero when absent)
//   reseed_ctr_in   current reseed counter
//   out_valid       random block valid
//   out_ready       consumer accepts block
//   out_data        random block
//   done            one-cycle pulse; key_out/v_out/reseed_ctr_out updated
//   err             one-cycle pulse; request rejected
//   reseed_req      with err: reseed counter exhausted
//   key_out, v_out  new working state (held until the next done)
//   reseed_ctr_out  reseed_ctr_in + 1 (held until the next done)
// ---------------------------------------------------------------------------
module ctr_drbg_generate
    import ctr_drbg_pkg::*;
#(
    parameter  int MAX_BLOCKS      = 16,
    parameter  int RESEED_INTERVAL = 1024,
    parameter  int ENC_LAT         = 1,
    localparam int NBW             = $clog2(MAX_BLOCKS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [NBW-1:0]      req_nblocks,
    input  logic [KEYLEN-1:0]   key_in,
    input  logic [BLOCKLEN-1:0] v_in,
    input  logic [SEEDLEN-1:0]  add_in,
    input  logic [31:0]         reseed_ctr_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLOCKLEN-1:0] out_data,
    output logic                done,
    output logic                err,
    output logic                reseed_req,
    output logic [KEYLEN-1:0]   key_out,
    output logic [BLOCKLEN-1:0] v_out,
    output logic [31:0]         reseed_ctr_out
);

    state_t         state;

    // Request captured at acceptance; later input changes are ignored.
    key_t           key_r;
    block_t         v_r;
    seed_t          add_r;
    logic [31:0]    ctr_r;
    logic [NBW-1:0] nb_r;

    logic [NBW-1:0] blk_left;
    seed_t          temp;
    logic           issue;

    logic           enc_start;
    logic           enc_done;
    block_t         enc_result;
    block_t         v_next;
    logic           handshake;
    logic           last_block;
    logic           ctr_exhausted;
    logic           nb_bad;
    seed_t          fin_seed;

    assign v_next        = v_r + block_t'(1);
    assign handshake     = out_valid && out_ready;
    assign last_block    = (blk_left == NBW'(1));
    assign ctr_exhausted = (ctr_r > 32'(RESEED_INTERVAL));
    assign nb_bad        = (nb_r == '0) || (nb_r > NBW'(MAX_BLOCKS));
    assign fin_seed      = temp ^ add_r;

    // Cipher issue points:
    //  - issue: first GEN block and the UPD0 block (registered one-shot)
    //  - GEN handshake with blocks still to go: the next block is issued in
    //    the handshake cycle itself so blocks stream every ENC_LAT+1 cycles
    //  - UPD0 result arriving: UPD1 is issued back-to-back
    // V is incremented exactly when a block is issued, so the cipher always
    // sees the counter value that the block consumes.
    assign enc_start = issue
                    || (state == ST_GEN  && handshake && !last_block)
                    || (state == ST_UPD0 && enc_done);

    ctr_drbg_block_cipher #(
        .ENC_LAT (ENC_LAT)
    ) u_cipher (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (enc_start),
        .key    (key_r),
        .block  (v_next),
        .done   (enc_done),
        .result (enc_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            req_ready      <= 1'b1;
            key_r          <= '0;
            v_r            <= '0;
            add_r          <= '0;
            ctr_r          <= '0;
            nb_r           <= '0;
            blk_left       <= '0;
            temp           <= '0;
            issue          <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
            reseed_req     <= 1'b0;
            key_out        <= '0;
            v_out          <= '0;
            reseed_ctr_out <= '0;
        end else begin
            // Pulses default low; each state raises them for one cycle.
            done       <= 1'b0;
            err        <= 1'b0;
            reseed_req <= 1'b0;
            issue      <= 1'b0;

            if (enc_start) begin
                v_r <= v_next;
            end

            unique case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        key_r     <= key_in;
                        v_r       <= v_in;
                        add_r     <= add_in;
                        ctr_r     <= reseed_ctr_in;
                        nb_r      <= req_nblocks;
                        req_ready <= 1'b0;
                        state     <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (ctr_exhausted) begin
                        err        <= 1'b1;
                        reseed_req <= 1'b1;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (nb_bad) begin
                        err       <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        blk_left <= nb_r;
                        issue    <= 1'b1;
                        state    <= ST_GEN;
                    end
                end

                ST_GEN: begin
                    // A new result can only arrive after the previous block
                    // has been handed over, so load and handshake never clash.
                    if (enc_done) begin
                        out_valid <= 1'b1;
                        out_data  <= enc_result;
                    end
                    if (handshake) begin
                        out_valid <= 1'b0;
                        blk_left  <= blk_left - NBW'(1);
                        if (last_block) begin
                            issue <= 1'b1;
                            state <= ST_UPD0;
                        end
                    end
                end

                ST_UPD0: begin
                    if (enc_done) begin
                        temp[SEEDLEN-1:BLOCKLEN] <= enc_result;
                        state                    <= ST_UPD1;
                    end
                end

                ST_UPD1: begin
                    if (enc_done) begin
                        temp[BLOCKLEN-1:0] <= enc_result;
                        state              <= ST_FIN;
                    end
                end

                ST_FIN: begin
                    key_out        <= fin_seed[SEEDLEN-1 -: KEYLEN];
                    v_out          <= fin_seed[BLOCKLEN-1:0];
                    reseed_ctr_out <= ctr_r + 32'd1;
                    done           <= 1'b1;
                    req_ready      <= 1'b1;
                    state          <= ST_IDLE;
                end

                default: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
